// File: rtl/mac_pkg.sv
// Shared types and constants for the multiply-accumulate slice.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OPER_W = 4;
    localparam int PROD_W = 8;

endpackage

// File: rtl/multiplier.sv
// 4x4 unsigned combinational multiplier; cout flags a carry past 8 bits.
module multiplier (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] PRODUCT,
    output logic       cout
);

    logic [8:0] full;

    // Full-width product; cout stays 0 for 4-bit operands.
    always_comb begin
        full    = 9'(A) * 9'(B);
        PRODUCT = full[7:0];
        cout    = full[8];
    end

endmodule

// File: rtl/mac_accumulator.sv
// Streaming dot-product engine: accepts len operand pairs, sums their
// products into a wide accumulator and hands the total downstream.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [CNT_W-1:0]   remaining;
    logic [PROD_W-1:0]  product;
    logic [ACC_W:0]     sum;
    logic               beat;

    multiplier u_mult (
        .A       (in_a),
        .B       (in_b),
        .PRODUCT (product),
        .cout    ()
    );

    // Carry-extended add of the accumulator and the zero-extended product.
    always_comb begin
        sum = {1'b0, acc} + (ACC_W+1)'(product);
    end

    // Next-state decode; handshake outputs depend on state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        beat      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                beat     = in_valid;
                if (in_valid && (remaining == CNT_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator, sticky overflow and term counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else if ((state_q == IDLE) && start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= len;
        end else if (beat) begin
            acc       <= sum[ACC_W-1:0];
            ovf       <= ovf | sum[ACC_W];
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (16-bit and 8-bit builds).
module tb_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic        out_ready;

    logic        w_in_ready;
    logic        w_out_valid;
    logic [15:0] w_out_acc;
    logic        w_out_ovf;
    logic        w_busy;

    logic        n_in_ready;
    logic        n_out_valid;
    logic [7:0]  n_out_acc;
    logic        n_out_ovf;
    logic        n_busy;

    int n_checks;
    int n_fail;

    mac_accumulator #(.ACC_W(16), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_acc   (w_out_acc),
        .out_ovf   (w_out_ovf),
        .busy      (w_busy)
    );

    mac_accumulator #(.ACC_W(8), .CNT_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (n_in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (n_out_valid),
        .out_ready (out_ready),
        .out_acc   (n_out_acc),
        .out_ovf   (n_out_ovf),
        .busy      (n_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", w_in_ready); end
        n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd0) begin n_fail++; $display("FAIL rst_out_acc got=%0d exp=0", w_out_acc); end
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", w_busy); end
        rst = 1'b0;
        step();
        // Start len=4, accept two beats, then reset asynchronously mid-cycle.
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
        step();
        step();
        in_valid = 1'b0;
        n_checks++; if (w_out_acc !== 16'd12) begin n_fail++; $display("FAIL partial_acc got=%0d exp=12", w_out_acc); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_in_ready got=%b exp=0", w_in_ready); end
        n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_out_valid got=%b exp=0", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd0) begin n_fail++; $display("FAIL midrun_rst_out_acc got=%0d exp=0", w_out_acc); end
        n_checks++; if (w_out_ovf !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_out_ovf got=%b exp=0", w_out_ovf); end
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_busy got=%b exp=0", w_busy); end
        step();
        rst = 1'b0;
        step();
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid got=%b exp=1", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd1) begin n_fail++; $display("FAIL post_rst_acc got=%0d exp=1", w_out_acc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle busy got=%b exp=0", w_busy); end
    endtask

    task automatic test_basic_sum();
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        n_checks++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", w_in_ready); end
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd5;
        step();
        in_a = 4'd15; in_b = 4'd15;
        step();
        n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got=%b exp=0", w_out_valid); end
        in_a = 4'd2; in_b = 4'd7;
        step();
        in_valid = 1'b0;
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency got=%b exp=1", w_out_valid); end
        n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_done_in_ready got=%b exp=0", w_in_ready); end
        n_checks++; if (w_out_acc !== 16'd254) begin n_fail++; $display("FAIL basic_acc got=%0d exp=254", w_out_acc); end
        n_checks++; if (w_out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", w_out_ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle busy got=%b exp=0", w_busy); end
    endtask

    task automatic test_stalls();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        int k;
        va[0] = 4'd3;  vb[0] = 4'd5;
        va[1] = 4'd15; vb[1] = 4'd15;
        va[2] = 4'd2;  vb[2] = 4'd7;
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = vb[i];
            step();
            in_valid = 1'b0;
            if (i < 2) begin
                step();
                step();
                n_checks++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready beat=%0d got=%b exp=1", i, w_in_ready); end
                n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid beat=%0d got=%b exp=0", i, w_out_valid); end
            end
        end
        k = 0;
        while (w_out_valid !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_done_wait got=%b exp=1", w_out_valid); end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid cyc=%0d got=%b exp=1", c, w_out_valid); end
            n_checks++; if (w_out_acc !== 16'd254) begin n_fail++; $display("FAIL stall_hold_acc cyc=%0d got=%0d exp=254", c, w_out_acc); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_handoff valid got=%b exp=0", w_out_valid); end
        step();
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL stall_single_handoff busy got=%b exp=0", w_busy); end
    endtask

    task automatic test_zero_len();
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_in_ready got=%b exp=0", w_in_ready); end
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_out_valid got=%b exp=1", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd0) begin n_fail++; $display("FAIL zero_acc got=%0d exp=0", w_out_acc); end
        n_checks++; if (w_out_ovf !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got=%b exp=0", w_out_ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle busy got=%b exp=0", w_busy); end
    endtask

    task automatic test_overflow();
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
        step();
        step();
        in_valid = 1'b0;
        n_checks++; if (n_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf8_valid got=%b exp=1", n_out_valid); end
        n_checks++; if (n_out_acc !== 8'd194) begin n_fail++; $display("FAIL ovf8_acc got=%0d exp=194", n_out_acc); end
        n_checks++; if (n_out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf8_flag got=%b exp=1", n_out_ovf); end
        n_checks++; if (w_out_acc !== 16'd450) begin n_fail++; $display("FAIL ovf16_acc got=%0d exp=450", w_out_acc); end
        n_checks++; if (w_out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf16_flag got=%b exp=0", w_out_ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
        step();
        in_valid = 1'b0;
        n_checks++; if (n_out_acc !== 8'd6) begin n_fail++; $display("FAIL ovf8_next_acc got=%0d exp=6", n_out_acc); end
        n_checks++; if (n_out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf8_next_flag got=%b exp=0", n_out_ovf); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0; in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        step();
        // Start during RUN must neither reload the count nor clear the sum.
        in_valid = 1'b0; start = 1'b1; len = 8'd7;
        step();
        start = 1'b0;
        n_checks++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL ign_run_in_ready got=%b exp=1", w_in_ready); end
        n_checks++; if (w_out_acc !== 16'd2) begin n_fail++; $display("FAIL ign_run_acc got=%0d exp=2", w_out_acc); end
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
        step();
        in_a = 4'd5; in_b = 4'd1;
        step();
        in_valid = 1'b0;
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_done_valid got=%b exp=1", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd19) begin n_fail++; $display("FAIL ign_done_acc got=%0d exp=19", w_out_acc); end
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_done_hold_valid got=%b exp=1", w_out_valid); end
        n_checks++; if (w_out_acc !== 16'd19) begin n_fail++; $display("FAIL ign_done_hold_acc got=%0d exp=19", w_out_acc); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle busy got=%b exp=0", w_busy); end
        step();
        n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue valid got=%b exp=0", w_out_valid); end
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_queue busy got=%b exp=0", w_busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic_sum();
        test_stalls();
        test_zero_len();
        test_overflow();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
